// File: rtl/core_pkg.sv
// Shared core types and constants for the front end.
package core_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// holds the returned instruction for decode until it is accepted or squashed.
module fetch_stage
  import core_pkg::*;
#(
  parameter int XLEN = ADDR_W,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] new_pc,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_4,
  input  logic            if_ready
);

  // Handshakes: a request transfers when imem_req_valid && imem_req_ready,
  // a decode transfer when if_valid && if_ready; imem_rsp_valid is a one-cycle
  // pulse with no back-pressure and is only meaningful in S_WAIT.

  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, req_pc;
  logic [XLEN-1:0] out_instr, out_pc, out_pc_4;
  logic            drop, drop_next;
  logic            req_fire, xfer, rsp_take;
  logic            unused_new_pc_low;

  assign unused_new_pc_low = ^new_pc[1:0];

  // rst_n gates the request so nothing is offered while reset is held.
  assign imem_req_valid = rst_n && (state == S_REQ) && !stall && !redirect;
  assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid = (state == S_FULL);
  assign if_instr = out_instr;
  assign if_pc    = out_pc;
  assign if_pc_4  = out_pc_4;
  assign xfer     = if_valid && if_ready;

  assign rsp_take = (state == S_WAIT) && imem_rsp_valid && !drop && !redirect;

  always_comb begin
    state_next = state;
    drop_next  = drop;
    case (state)
      S_REQ: begin
        if (req_fire) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_next = rsp_take ? S_FULL : S_REQ;
          drop_next  = 1'b0;
        end else if (redirect) begin
          drop_next = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect || xfer) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  // Redirect wins over the increment; a fire cannot coincide with it anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (redirect) begin
        pc <= {new_pc[XLEN-1:2], 2'b00};
      end else if (req_fire) begin
        pc <= pc + STEP;
      end
      if (req_fire) req_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr <= '0;
      out_pc    <= '0;
      out_pc_4  <= '0;
    end else if (rsp_take) begin
      out_instr <= imem_rsp_data;
      out_pc    <= req_pc;
      out_pc_4  <= req_pc + STEP;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model with configurable latency
// and a scoreboard of expected decode transfers.
module tb_fetch_stage;
  import core_pkg::*;

  localparam int XLEN = 32;
  localparam int W = 3 * XLEN;
  localparam addr_t RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  addr_t       new_pc;
  logic        stall;
  logic        imem_req_valid;
  addr_t       imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  addr_t       imem_rsp_data;
  logic        if_valid;
  addr_t       if_instr;
  addr_t       if_pc;
  addr_t       if_pc_4;
  logic        if_ready;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect       (redirect),
    .new_pc         (new_pc),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_4        (if_pc_4),
    .if_ready       (if_ready)
  );

  logic [W-1:0] exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  addr_t exp_pc;
  bit    inflight;
  bit    mem_pending;
  int    mem_cnt;
  int    mem_lat = 1;
  addr_t mem_addr;
  bit    saw_xfer, saw_fire;
  int    cyc = 0;

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic addr_t instr_of(addr_t a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [W-1:0] pack(addr_t p);
    addr_t p4;
    p4 = p + 32'd4;
    return {instr_of(p), p, p4};
  endfunction

  // One clock: observe at negedge+1, update model, advance to next negedge.
  task automatic cycle();
    logic [W-1:0] e;
    #1;
    saw_xfer = 1'b0;
    saw_fire = 1'b0;
    if (if_valid && if_ready) begin
      saw_xfer = 1'b1;
      inflight = 1'b0;
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("decode", {if_instr, if_pc, if_pc_4}, e);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      saw_fire = 1'b1;
      check("req_addr", imem_req_addr, exp_pc);
      exp_q.push_back(pack(exp_pc));
      inflight    = 1'b1;
      mem_pending = 1'b1;
      mem_cnt     = mem_lat;
      mem_addr    = imem_req_addr;
      exp_pc      = exp_pc + 32'd4;
    end
    if (redirect) begin
      check("req_valid_on_redirect", imem_req_valid, 0);
      if (inflight) begin
        void'(exp_q.pop_back());
        inflight = 1'b0;
      end
      exp_pc = {new_pc[31:2], 2'b00};
    end
    @(negedge clk);
    cyc++;
    redirect       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_pending) begin
      if (mem_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mem_addr);
        mem_pending    = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic run_until_xfer(string tag, int bound);
    bit got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      cycle();
      got = saw_xfer;
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_until_fire(string tag, int bound);
    bit got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      cycle();
      got = saw_fire;
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_until_valid(string tag, int bound);
    bit got;
    got = if_valid;
    for (int i = 0; i < bound && !got; i++) begin
      cycle();
      got = if_valid;
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    inflight    = 1'b0;
    mem_pending = 1'b0;
    exp_pc      = RST_PC;
  endtask

  initial begin
    int t0;
    rst_n          = 1'b0;
    redirect       = 1'b0;
    new_pc         = '0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b1;
    clear_model();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_pc_4", if_pc_4, 0);
    check("rst_req_valid", imem_req_valid, 0);
    rst_n = 1'b1;
    #1;
    check("rel_req_valid", imem_req_valid, 1);

    // Straight-line fetch of 0x0, 0x4, 0x8 at one instruction per 3 cycles
    run_until_xfer("t1_a", 20);
    t0 = cyc;
    run_until_xfer("t1_b", 20);
    check("t1_spacing_b", cyc - t0, 3);
    t0 = cyc;
    run_until_xfer("t1_c", 20);
    check("t1_spacing_c", cyc - t0, 3);

    // Memory not ready for 4 cycles at 0x4
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    run_until_xfer("t2_first", 20);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_valid", imem_req_valid, 1);
      check("t2_hold_addr", imem_req_addr, 32'h4);
      cycle();
    end
    imem_req_ready = 1'b1;
    run_until_xfer("t2_done", 20);

    // Redirect while waiting for 0x8 with slow memory: 0x8 is dropped
    mem_lat = 3;
    run_until_fire("t3_fire", 20);
    redirect = 1'b1;
    new_pc   = 32'h100;
    cycle();
    mem_lat = 1;
    run_until_xfer("t3_xfer", 30);
    check("t3_pc", if_pc, 32'h100);

    // Redirect coincident with the response
    run_until_fire("t3b_fire", 20);
    redirect = 1'b1;
    new_pc   = 32'h180;
    cycle();
    run_until_xfer("t3b_xfer", 30);

    // Held instruction under back-pressure and stall, then squashed
    if_ready = 1'b0;
    run_until_valid("t4_valid", 20);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", if_valid, 1);
      check("t4_hold_data", {if_instr, if_pc, if_pc_4}, pack(32'h184));
      cycle();
    end
    redirect = 1'b1;
    new_pc   = 32'h203;
    cycle();
    check("t4_squash_valid", if_valid, 0);
    stall    = 1'b0;
    if_ready = 1'b1;
    run_until_fire("t4_fire", 20);
    run_until_xfer("t4_xfer", 20);

    // PC wrap at the top of the address space
    redirect = 1'b1;
    new_pc   = 32'hFFFF_FFFC;
    cycle();
    run_until_xfer("t5_xfer", 20);
    check("t5_pc_4", if_pc_4, 32'h0);
    run_until_fire("t5_wrap_fire", 20);
    run_until_xfer("t5_wrap_xfer", 20);

    // Reset asserted mid-fetch, then a stray response
    mem_lat = 3;
    run_until_fire("t6_fire", 20);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("t6_rst_if_valid", if_valid, 0);
    check("t6_rst_req_valid", imem_req_valid, 0);
    @(negedge clk);
    rst_n          = 1'b1;
    stall          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    cycle();
    check("t6_stray_if_valid", if_valid, 0);
    check("t6_stall_req_valid", imem_req_valid, 0);
    stall   = 1'b0;
    mem_lat = 1;
    run_until_fire("t6_refetch", 20);
    run_until_xfer("t6_xfer", 20);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
